// File: rtl/exp_pkg.sv
// Shared constants, state encoding and LUT generator for the fixed-point exp unit.
package exp_pkg;

    localparam int DATA_SIZE     = 32;
    localparam int LUT_ADDR_SIZE = 8;
    localparam int LUT_DEPTH     = 256;
    localparam int LUT_WIDTH     = 32;

    localparam logic [31:0] LN2_Q28 = 32'h0B17217F;
    localparam logic [31:0] ONE_Q30 = 32'h4000_0000;

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        LUT,
        INTERP,
        OUT
    } exp_state_t;

    // floor(exp(-idx/256) * 2^30), evaluated as a Taylor series in Q60 so the
    // table is built at elaboration without real arithmetic.
    function automatic logic [31:0] exp_neg_q30(input int unsigned idx);
        logic [79:0] term;
        logic [79:0] pos;
        logic [79:0] neg;
        term = 80'd1 << 60;
        pos  = term;
        neg  = '0;
        for (int n = 1; n < 24; n++) begin
            term = (term * 80'(idx)) / (80'd256 * 80'(n));
            if ((n % 2) == 1) neg = neg + term;
            else              pos = pos + term;
        end
        return 32'((pos - neg) >> 30);
    endfunction

endpackage

// File: rtl/exp_lut.sv
// 256 x 32 ROM of exp(-i/256) in Q2.30 with a registered output and valid strobe.
module exp_lut
    import exp_pkg::*;
#(
    parameter int data_size     = DATA_SIZE,
    parameter int lut_addr_size = LUT_ADDR_SIZE
) (
    input  logic                     clock_i,
    input  logic                     reset_n_i,
    input  logic [lut_addr_size-1:0] lut_exp_data_i,
    input  logic                     lut_exp_data_valid_i,
    output logic [data_size-1:0]     lut_exp_data_o,
    output logic                     lut_exp_data_valid_o
);

    logic [LUT_WIDTH-1:0] rom [LUT_DEPTH];

    for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_rom
        assign rom[g] = exp_neg_q30(g);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lut_exp_data_valid_o <= 1'b0;
        end else begin
            lut_exp_data_valid_o <= lut_exp_data_valid_i;
        end
    end

    // Data path is not reset; it is only consumed after the valid strobe.
    always_ff @(posedge clock_i) begin
        if (lut_exp_data_valid_i) begin
            lut_exp_data_o <= rom[lut_exp_data_i];
        end
    end

endmodule

// File: rtl/exp_block.sv
// Fixed-point exp(x): signed Q4.28 in, unsigned Q2.30 out, via ln2 range reduction and a LUT.
// Define EXP_INTERP_EN to add a linear-interpolation stage between the LUT and the output shift.
module exp_block
    import exp_pkg::*;
#(
    parameter int data_size     = DATA_SIZE,
    parameter int lut_addr_size = LUT_ADDR_SIZE
) (
    input  logic                        clock_i,
    input  logic                        reset_n_i,
    input  logic signed [data_size-1:0] exp_data_i,
    input  logic                        exp_data_valid_i,
    output logic                        exp_data_ready_o,
    output logic [data_size-1:0]        exp_data_o,
    output logic                        exp_data_valid_o
);

    exp_state_t               state_q, state_d;
    logic [data_size-1:0]     m_q, m_d;
    logic [3:0]               k_q, k_d;
    logic [data_size-1:0]     data_d;
    logic                     valid_d;
    logic                     ready_d;
    logic                     accept;
    logic [data_size-1:0]     neg_x;
    logic [lut_addr_size-1:0] lut_addr;
    logic                     lut_strobe;
    logic [data_size-1:0]     lut_q;
    logic                     lut_valid;
    logic [data_size-1:0]     out_base;
`ifdef EXP_INTERP_EN
    logic [data_size-1:0]     y_q, y_d;
`endif

    function automatic logic [31:0] shift_by_k(input logic [31:0] val, input logic [3:0] sh);
        return val >> sh;
    endfunction

    // exp(-(i+f)/256) ~= lut[i] * (1 - f/256), f = m[19:0] / 2^20
    function automatic logic [31:0] interp_lin(input logic [31:0] base, input logic [19:0] frac);
        logic [51:0] prod;
        prod = 52'(base) * 52'(frac);
        return base - 32'(prod >> 28);
    endfunction

    assign accept = exp_data_valid_i && exp_data_ready_o;
    assign neg_x  = -exp_data_i;

`ifdef EXP_INTERP_EN
    assign out_base = y_q;
`else
    assign out_base = lut_q;
`endif

    exp_lut #(
        .data_size    (data_size),
        .lut_addr_size(lut_addr_size)
    ) u_lut (
        .clock_i             (clock_i),
        .reset_n_i           (reset_n_i),
        .lut_exp_data_i      (lut_addr),
        .lut_exp_data_valid_i(lut_strobe),
        .lut_exp_data_o      (lut_q),
        .lut_exp_data_valid_o(lut_valid)
    );

    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        k_d        = k_q;
        data_d     = exp_data_o;
        valid_d    = 1'b0;
        ready_d    = exp_data_ready_o;
        lut_strobe = 1'b0;
        lut_addr   = m_q[27:20];
`ifdef EXP_INTERP_EN
        y_d        = y_q;
`endif
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    // Positive operands clamp to x = 0; 0x8000_0000 yields m = 8.0.
                    ready_d = 1'b0;
                    m_d     = exp_data_i[data_size-1] ? neg_x : '0;
                    k_d     = '0;
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                if (m_q >= LN2_Q28) begin
                    m_d = m_q - LN2_Q28;
                    k_d = k_q + 4'd1;
                end else begin
                    lut_strobe = 1'b1;
                    state_d    = LUT;
                end
            end
            LUT: begin
                if (lut_valid) begin
`ifdef EXP_INTERP_EN
                    state_d = INTERP;
`else
                    state_d = OUT;
`endif
                end
            end
`ifdef EXP_INTERP_EN
            INTERP: begin
                y_d     = interp_lin(lut_q, m_q[19:0]);
                state_d = OUT;
            end
`else
            INTERP: begin
                state_d = IDLE;
            end
`endif
            OUT: begin
                data_d  = shift_by_k(out_base, k_q);
                valid_d = 1'b1;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q          <= IDLE;
            m_q              <= '0;
            k_q              <= '0;
            exp_data_o       <= '0;
            exp_data_valid_o <= 1'b0;
            exp_data_ready_o <= 1'b0;
        end else begin
            state_q          <= state_d;
            m_q              <= m_d;
            k_q              <= k_d;
            exp_data_o       <= data_d;
            exp_data_valid_o <= valid_d;
            exp_data_ready_o <= ready_d;
        end
    end

`ifdef EXP_INTERP_EN
    always_ff @(posedge clock_i) begin
        y_q <= y_d;
    end
`endif

endmodule

// File: tb/tb_exp_block.sv
// Directed self-checking bench for exp_block: latency, values, back-to-back flow and async reset.
`timescale 1ns/1ps
module tb_exp_block;

    logic               clock_i = 1'b0;
    logic               reset_n_i;
    logic signed [31:0] exp_data_i;
    logic               exp_data_valid_i;
    logic               exp_data_ready_o;
    logic [31:0]        exp_data_o;
    logic               exp_data_valid_o;

    int checks = 0;
    int errors = 0;

`ifdef EXP_INTERP_EN
    localparam int EXTRA  = 1;
    localparam bit INTERP = 1'b1;
`else
    localparam int EXTRA  = 0;
    localparam bit INTERP = 1'b0;
`endif

    always #5 clock_i = ~clock_i;

    exp_block dut (
        .clock_i         (clock_i),
        .reset_n_i       (reset_n_i),
        .exp_data_i      (exp_data_i),
        .exp_data_valid_i(exp_data_valid_i),
        .exp_data_ready_o(exp_data_ready_o),
        .exp_data_o      (exp_data_o),
        .exp_data_valid_o(exp_data_valid_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a posedge with ready high; leaves at #1 after a posedge.
    task automatic do_op(input string tag, input logic [31:0] x, input int lat,
                         input logic [31:0] exp_val, input logic [31:0] tol);
        int          edges;
        logic        seen;
        logic [31:0] got;
        logic [31:0] diff;
        exp_data_i       = x;
        exp_data_valid_i = 1'b1;
        @(posedge clock_i); #1;
        exp_data_valid_i = 1'b0;
        check({tag, "_ready_low"}, {31'd0, exp_data_ready_o}, 32'd0);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clock_i); #1;
            edges++;
            if (exp_data_valid_o) seen = 1'b1;
        end
        check({tag, "_latency"}, edges, lat);
        got  = exp_data_o;
        diff = (got > exp_val) ? got - exp_val : exp_val - got;
        checks++;
        assert (seen && diff <= tol) else begin
            errors++;
            $error("FAIL %s_value: observed %h expected %h tol %0d", tag, got, exp_val, tol);
        end
        check({tag, "_ready_with_valid"}, {31'd0, exp_data_ready_o}, 32'd1);
        @(posedge clock_i); #1;
        check({tag, "_valid_pulse"}, {31'd0, exp_data_valid_o}, 32'd0);
    endtask

    logic [31:0] ops [3];
    logic [31:0] res [3];
    int          idx;
    int          nres;
    int          pulses;
    logic        took;

    initial begin
        reset_n_i        = 1'b0;
        exp_data_i       = '0;
        exp_data_valid_i = 1'b0;
        repeat (2) @(posedge clock_i);
        #1;
        check("rst_data",  exp_data_o, 32'd0);
        check("rst_valid", {31'd0, exp_data_valid_o}, 32'd0);
        check("rst_ready", {31'd0, exp_data_ready_o}, 32'd0);
        @(negedge clock_i);
        reset_n_i = 1'b1;
        @(posedge clock_i); #1;
        check("ready_after_rst", {31'd0, exp_data_ready_o}, 32'd1);

        do_op("zero",   32'h0000_0000, 3 + EXTRA,  32'h4000_0000, 32'd0);
        do_op("negln2", 32'hF4E8_DE81, 4 + EXTRA,  32'h2000_0000, 32'd0);
        do_op("neg1",   32'hF000_0000, 4 + EXTRA,  32'h178B_5636, INTERP ? 32'd12055 : 32'd1580000);
        do_op("pos",    32'h1000_0000, 3 + EXTRA,  32'h4000_0000, 32'd0);
        do_op("neg8",   32'h8000_0000, 14 + EXTRA, 32'd360199,    INTERP ? 32'd11 : 32'd1440);

        // Continuous valid; junk (-2.0) is presented whenever ready is low and must be dropped.
        ops[0] = 32'h0000_0000;
        ops[1] = 32'hF4E8_DE81;
        ops[2] = 32'h7FFF_FFFF;
        idx  = 0;
        nres = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (exp_data_valid_o) begin
                if (nres < 3) res[nres] = exp_data_o;
                nres++;
            end
            took = 1'b0;
            if (exp_data_ready_o && idx < 3) begin
                exp_data_i       = ops[idx];
                exp_data_valid_i = 1'b1;
                took             = 1'b1;
            end else if (idx < 3) begin
                exp_data_i       = 32'hE000_0000;
                exp_data_valid_i = 1'b1;
            end else begin
                exp_data_valid_i = 1'b0;
            end
            @(posedge clock_i); #1;
            if (took) idx++;
        end
        exp_data_valid_i = 1'b0;
        check("b2b_count", nres, 3);
        check("b2b_res0", res[0], 32'h4000_0000);
        check("b2b_res1", res[1], 32'h2000_0000);
        check("b2b_res2", res[2], 32'h4000_0000);

        // Reset pulled asynchronously while the unit is reducing a -8.0 operand.
        exp_data_i       = 32'h8000_0000;
        exp_data_valid_i = 1'b1;
        @(posedge clock_i); #1;
        exp_data_valid_i = 1'b0;
        repeat (4) @(posedge clock_i);
        #3;
        reset_n_i = 1'b0;
        #1;
        check("mid_rst_data",  exp_data_o, 32'd0);
        check("mid_rst_valid", {31'd0, exp_data_valid_o}, 32'd0);
        check("mid_rst_ready", {31'd0, exp_data_ready_o}, 32'd0);
        @(negedge clock_i);
        reset_n_i = 1'b1;
        @(posedge clock_i); #1;
        check("mid_rst_ready_rise", {31'd0, exp_data_ready_o}, 32'd1);
        pulses = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clock_i); #1;
            if (exp_data_valid_o) pulses++;
        end
        check("mid_rst_no_valid", pulses, 0);
        check("mid_rst_data_kept", exp_data_o, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
